// File: rtl/load_store_sequencer.sv
// load_store_sequencer: RV32I load/store bus sequencer with lane steering, load extension and fault reporting.
module load_store_sequencer #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [7:0]  alu_operation,
  input  logic [31:0] address,
  input  logic [31:0] store_data,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_load_data,
  output logic        resp_fault,
  output logic [1:0]  resp_fault_cause,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);
  localparam logic [7:0] OP_LB = 8'h20, OP_LH = 8'h21, OP_LW = 8'h22, OP_LBU = 8'h24, OP_LHU = 8'h25;
  localparam logic [7:0] OP_SB = 8'h28, OP_SH = 8'h29, OP_SW = 8'h2A;
  localparam int CW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES == 0 ? 0 : TIMEOUT_CYCLES - 1);
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_t;
  state_t r_state, w_next;
  logic [7:0]    r_op;
  logic [31:0]   r_addr, r_wdata, r_data;
  logic [3:0]    r_wstrb;
  logic [1:0]    r_cause;
  logic [CW-1:0] r_cnt;
  logic r_req_ready, r_mem_req, r_mem_we, r_resp_valid, r_fault;
  logic w_accept, w_is_load, w_is_store, w_mis, w_go, w_expire;
  logic [31:0] w_wdata, w_shift, w_ld;
  logic [3:0]  w_wstrb;
  always_comb begin
    w_accept   = req_valid & r_req_ready;
    w_is_load  = alu_operation inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
    w_is_store = alu_operation inside {OP_SB, OP_SH, OP_SW};
    w_mis      = (alu_operation inside {OP_LH, OP_LHU, OP_SH} && address[0]) ||
                 (alu_operation inside {OP_LW, OP_SW} && address[1:0] != 2'b00);
    w_go       = (w_is_load | w_is_store) & ~w_mis;
    w_expire   = (TIMEOUT_CYCLES != 0) && (r_cnt == LIMIT);
    w_wdata    = alu_operation == OP_SB ? {4{store_data[7:0]}} :
                 alu_operation == OP_SH ? {2{store_data[15:0]}} : store_data;
    w_wstrb    = alu_operation == OP_SB ? 4'b0001 << address[1:0] :
                 alu_operation == OP_SH ? 4'b0011 << {address[1], 1'b0} :
                 alu_operation == OP_SW ? 4'b1111 : 4'b0000;
    w_shift    = mem_rdata >> {r_addr[1:0], 3'b000};
    w_ld       = r_op == OP_LB  ? {{24{w_shift[7]}}, w_shift[7:0]} :
                 r_op == OP_LBU ? {24'b0, w_shift[7:0]} :
                 r_op == OP_LH  ? {{16{w_shift[15]}}, w_shift[15:0]} :
                 r_op == OP_LHU ? {16'b0, w_shift[15:0]} :
                 r_op == OP_LW  ? w_shift : 32'b0;
    w_next     = r_state == S_IDLE ? (w_accept ? (w_go ? S_REQ : S_RESP) : S_IDLE) :
                 r_state == S_REQ  ? ((mem_ack | w_expire) ? S_RESP : S_REQ) :
                 (resp_ready ? S_IDLE : S_RESP);
  end
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else r_state <= w_next;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_req_ready  <= 1'b0;
      r_mem_req    <= 1'b0;
      r_resp_valid <= 1'b0;
      r_op         <= 8'b0;
      r_addr       <= 32'b0;
      r_mem_we     <= 1'b0;
      r_wdata      <= 32'b0;
      r_wstrb      <= 4'b0;
      r_cnt        <= '0;
      r_data       <= 32'b0;
      r_fault      <= 1'b0;
      r_cause      <= 2'b0;
    end else begin
      r_req_ready  <= w_next == S_IDLE;
      r_mem_req    <= w_next == S_REQ;
      r_resp_valid <= w_next == S_RESP;
      if (w_accept) begin
        r_op     <= alu_operation;
        r_addr   <= address;
        r_mem_we <= w_is_store;
        r_wdata  <= w_wdata;
        r_wstrb  <= w_wstrb;
        r_cnt    <= '0;
        r_data   <= 32'b0;
        r_fault  <= w_mis;
        r_cause  <= w_mis ? (w_is_store ? 2'd2 : 2'd1) : 2'd0;
      end
      // ack has priority over a timeout expiring in the same cycle
      if (r_state == S_REQ) begin
        r_cnt <= r_cnt + CW'(1);
        if (mem_ack) r_data <= w_ld;
        else if (w_expire) begin
          r_fault <= 1'b1;
          r_cause <= 2'd3;
        end
      end
    end
  end
  assign req_ready        = r_req_ready;
  assign resp_valid       = r_resp_valid;
  assign resp_load_data   = r_data;
  assign resp_fault       = r_fault;
  assign resp_fault_cause = r_cause;
  assign mem_req          = r_mem_req;
  assign mem_we           = r_mem_we;
  assign mem_addr         = {r_addr[31:2], 2'b00};
  assign mem_wdata        = r_wdata;
  assign mem_wstrb        = r_wstrb;
endmodule

// File: tb/tb_load_store_sequencer.sv
// tb_load_store_sequencer: directed scenario tests for load_store_sequencer.
module tb_load_store_sequencer;
  localparam logic [7:0] OP_NOP = 8'h00, OP_LB = 8'h20, OP_LH = 8'h21, OP_LW = 8'h22, OP_LBU = 8'h24, OP_LHU = 8'h25;
  localparam logic [7:0] OP_SB = 8'h28, OP_SH = 8'h29, OP_SW = 8'h2A;
  logic clk = 0, reset = 0, req_valid = 0, resp_ready = 0, mem_ack = 0;
  logic [7:0] alu_operation = 0;
  logic [31:0] address = 0, store_data = 0, mem_rdata = 0;
  logic req_ready, resp_valid, resp_fault, mem_req, mem_we;
  logic [31:0] resp_load_data, mem_addr, mem_wdata;
  logic [1:0] resp_fault_cause;
  logic [3:0] mem_wstrb;
  int n_cmp = 0, n_bad = 0;
  load_store_sequencer #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .alu_operation(alu_operation), .address(address), .store_data(store_data),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_load_data(resp_load_data),
    .resp_fault(resp_fault), .resp_fault_cause(resp_fault_cause),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_ack(mem_ack), .mem_rdata(mem_rdata));
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input logic [7:0] op, input logic [31:0] a, input logic [31:0] sd);
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL issue_ready op=%h: req_ready=%b want 1", op, req_ready);
    end
    alu_operation = op; address = a; store_data = sd; req_valid = 1;
    tick();
    req_valid = 0;
  endtask
  task automatic consume();
    resp_ready = 1;
    tick();
    resp_ready = 0;
    n_cmp++;
    if ({resp_valid, req_ready, mem_req} !== 3'b010) begin
      n_bad++;
      $display("FAIL consume: {valid,ready,mem_req}=%b want 010", {resp_valid, req_ready, mem_req});
    end
  endtask
  task automatic mem_txn(input string name, input logic [7:0] op, input logic [31:0] a, input logic [31:0] sd,
                         input logic [31:0] rd, input logic we, input logic [3:0] strb,
                         input logic [31:0] wd, input logic [31:0] exp_data);
    logic [31:0] wd_obs;
    issue(op, a, sd);
    wd_obs = we ? mem_wdata : 32'h0;
    n_cmp++;
    if ({resp_valid, mem_req, mem_we, mem_addr, mem_wstrb, wd_obs} !== {1'b0, 1'b1, we, a[31:2], 2'b00, strb, wd}) begin
      n_bad++;
      $display("FAIL %s_bus: req=%b we=%b addr=%h strb=%b wdata=%h rv=%b want req=1 we=%b addr=%h strb=%b wdata=%h rv=0",
               name, mem_req, mem_we, mem_addr, mem_wstrb, wd_obs, resp_valid, we, {a[31:2], 2'b00}, strb, wd);
    end
    mem_ack = 1; mem_rdata = rd;
    tick();
    mem_ack = 0; mem_rdata = 32'h0;
    n_cmp++;
    if ({resp_valid, mem_req, resp_fault, resp_fault_cause, resp_load_data} !== {1'b1, 1'b0, 1'b0, 2'd0, exp_data}) begin
      n_bad++;
      $display("FAIL %s_resp: valid=%b mem_req=%b fault=%b cause=%0d data=%h want valid=1 mem_req=0 fault=0 cause=0 data=%h",
               name, resp_valid, mem_req, resp_fault, resp_fault_cause, resp_load_data, exp_data);
    end
    consume();
  endtask
  task automatic test_reset();
    reset = 1;
    tick();
    n_cmp++;
    if ({req_ready, resp_valid, mem_req, resp_fault, mem_wstrb} !== 8'b0) begin
      n_bad++;
      $display("FAIL reset_outputs: ready=%b valid=%b mem_req=%b fault=%b strb=%b want all 0",
               req_ready, resp_valid, mem_req, resp_fault, mem_wstrb);
    end
    reset = 0;
    tick();
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_release: req_ready=%b want 1", req_ready);
    end
  endtask
  task automatic test_stores();
    mem_txn("sw", OP_SW, 32'h100, 32'hDEADBEEF, 32'h0, 1'b1, 4'b1111, 32'hDEADBEEF, 32'h0);
    mem_txn("sb", OP_SB, 32'h203, 32'h000000A5, 32'h0, 1'b1, 4'b1000, 32'hA5A5A5A5, 32'h0);
    mem_txn("sh", OP_SH, 32'h102, 32'h1234BEEF, 32'h0, 1'b1, 4'b1100, 32'hBEEFBEEF, 32'h0);
  endtask
  task automatic test_loads();
    mem_txn("lb", OP_LB, 32'h301, 32'h0, 32'h12348000, 1'b0, 4'b0000, 32'h0, 32'hFFFFFF80);
    mem_txn("lbu", OP_LBU, 32'h301, 32'h0, 32'h12348000, 1'b0, 4'b0000, 32'h0, 32'h00000080);
    mem_txn("lh", OP_LH, 32'h302, 32'h0, 32'h80010000, 1'b0, 4'b0000, 32'h0, 32'hFFFF8001);
    mem_txn("lhu", OP_LHU, 32'h302, 32'h0, 32'h80010000, 1'b0, 4'b0000, 32'h0, 32'h00008001);
    mem_txn("lw", OP_LW, 32'h104, 32'h0, 32'h89ABCDEF, 1'b0, 4'b0000, 32'h0, 32'h89ABCDEF);
  endtask
  task automatic test_faults();
    logic [7:0]  ops   [3] = '{OP_LW, OP_SH, OP_NOP};
    logic [31:0] addrs [3] = '{32'h102, 32'h101, 32'h0};
    logic [2:0]  exp   [3] = '{3'b101, 3'b110, 3'b000};
    for (int i = 0; i < 3; i++) begin
      issue(ops[i], addrs[i], 32'hFFFFFFFF);
      n_cmp++;
      if ({resp_valid, mem_req, resp_fault, resp_fault_cause, resp_load_data} !== {1'b1, 1'b0, exp[i], 32'h0}) begin
        n_bad++;
        $display("FAIL fault_%0d: valid=%b mem_req=%b fault=%b cause=%0d data=%h want valid=1 mem_req=0 fault/cause=%b data=0",
                 i, resp_valid, mem_req, resp_fault, resp_fault_cause, resp_load_data, exp[i]);
      end
      consume();
    end
  endtask
  task automatic test_timeout();
    int cnt = 0;
    issue(OP_LW, 32'h400, 32'h0);
    for (int i = 0; i < 40 && mem_req; i++) begin
      cnt++;
      tick();
    end
    n_cmp++;
    if (cnt !== 16 || {resp_valid, resp_fault, resp_fault_cause} !== 4'b1111) begin
      n_bad++;
      $display("FAIL timeout: req_cycles=%0d valid=%b fault=%b cause=%0d want 16 1 1 3",
               cnt, resp_valid, resp_fault, resp_fault_cause);
    end
    consume();
    issue(OP_LW, 32'h404, 32'h0);
    cnt = 0;
    for (int i = 0; i < 15; i++) begin
      cnt += int'(mem_req);
      tick();
    end
    mem_ack = 1; mem_rdata = 32'hCAFEF00D;
    cnt += int'(mem_req);
    tick();
    mem_ack = 0;
    n_cmp++;
    if (cnt !== 16 || {resp_valid, resp_fault, resp_fault_cause, resp_load_data} !== {4'b1000, 32'hCAFEF00D}) begin
      n_bad++;
      $display("FAIL ack_at_limit: req_cycles=%0d valid=%b fault=%b cause=%0d data=%h want 16 1 0 0 cafef00d",
               cnt, resp_valid, resp_fault, resp_fault_cause, resp_load_data);
    end
    consume();
  endtask
  task automatic test_backpressure();
    issue(OP_LH, 32'h502, 32'h0);
    mem_ack = 1; mem_rdata = 32'h7FFE1234;
    tick();
    mem_ack = 0; mem_rdata = 32'h0;
    for (int i = 0; i < 5; i++) begin
      req_valid = 1; mem_ack = 1; mem_rdata = 32'hFFFFFFFF;
      tick();
      n_cmp++;
      if ({resp_valid, req_ready, mem_req, resp_fault, resp_load_data} !== {4'b1000, 32'h00007FFE}) begin
        n_bad++;
        $display("FAIL hold_%0d: valid=%b ready=%b mem_req=%b fault=%b data=%h want 1 0 0 0 00007ffe",
                 i, resp_valid, req_ready, mem_req, resp_fault, resp_load_data);
      end
    end
    req_valid = 0; mem_ack = 0; mem_rdata = 32'h0;
    consume();
  endtask
  task automatic test_reset_in_req();
    issue(OP_SW, 32'h600, 32'h11111111);
    n_cmp++;
    if (mem_req !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_req_pre: mem_req=%b want 1", mem_req);
    end
    reset = 1;
    tick();
    reset = 0;
    n_cmp++;
    if ({mem_req, resp_valid, req_ready} !== 3'b000) begin
      n_bad++;
      $display("FAIL rst_req_cycle: {mem_req,valid,ready}=%b want 000", {mem_req, resp_valid, req_ready});
    end
    tick();
    n_cmp++;
    if ({mem_req, resp_valid, req_ready} !== 3'b001) begin
      n_bad++;
      $display("FAIL rst_req_after: {mem_req,valid,ready}=%b want 001", {mem_req, resp_valid, req_ready});
    end
    mem_txn("post_rst", OP_LBU, 32'h702, 32'h0, 32'h00AB0000, 1'b0, 4'b0000, 32'h0, 32'h000000AB);
  endtask
  initial begin
    test_reset();
    test_stores();
    test_loads();
    test_faults();
    test_timeout();
    test_backpressure();
    test_reset_in_req();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/load_store_sequencer.md
Name: load_store_sequencer

Overview:
- Execute-stage controller that sequences the data-memory bus for RV32I loads and stores.
- Consumes the decoded 8-bit alu_operation (ALU_OPERATIONS_LB/LH/LW/LBU/LHU/SB/SH/SW codes from common/isa.svh) together with the effective address and store data.
- Generates word-aligned bus requests with byte strobes, then returns sign- or zero-extended load data or a fault to the pipeline through a valid/ready response.
- One transaction in flight at a time.

Parameters:
- TIMEOUT_CYCLES, 16, number of REQ-state cycles without mem_ack before the access is aborted with a timeout fault; 0 disables the timeout.

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- req_valid  in  1  pipeline presents an operation
- req_ready  out  1  sequencer can accept (IDLE only)
- alu_operation  in  8  decoded operation code
- address  in  32  effective byte address (rs1+imm)
- store_data  in  32  rs2 value
- resp_valid  out  1  result available
- resp_ready  in  1  pipeline consumes result
- resp_load_data  out  32  extended load result; 0 for stores, faults and non-memory ops
- resp_fault  out  1  access faulted
- resp_fault_cause  out  2  0 none, 1 misaligned load, 2 misaligned store, 3 bus timeout
- mem_req  out  1  bus request, held until mem_ack
- mem_we  out  1  1 store, 0 load
- mem_addr  out  32  {address[31:2],2'b00}
- mem_wdata  out  32  lane-replicated store data
- mem_wstrb  out  4  byte enables; 0 for loads
- mem_ack  in  1  bus completes; mem_rdata valid this cycle
- mem_rdata  in  32  read word

Behaviour:
- States: IDLE, REQ, RESP.
- Reset (synchronous):
  - state=IDLE.
  - All outputs 0 in the reset cycle, including req_ready.
  - Captured request registers and timeout counter cleared.
  - Reset in REQ: mem_req is 0 the following cycle, the transaction is abandoned and no response is issued.
  - Reset in RESP: the pending response is dropped.
- IDLE:
  - req_ready=1.
  - On req_valid&req_ready, register op, address, store data and classify:
    - Load or store, aligned -> REQ.
    - Misaligned (H-type with addr[0]=1; W-type with addr[1:0]!=0) -> RESP with fault, cause 1 or 2. No bus cycle.
    - Any other code, including NOP -> RESP, no fault, resp_load_data=0, no bus cycle.
- REQ:
  - mem_req=1; mem_addr, mem_we, mem_wdata and mem_wstrb are registered and stable until the ack cycle.
  - On mem_ack: capture the extracted load data, go to RESP.
  - Timeout counter starts at 0 on REQ entry and increments each non-ack cycle. When it reaches TIMEOUT_CYCLES-1 without ack -> RESP with cause 3, mem_req dropped next cycle.
  - mem_ack in the same cycle as the timeout expires: ack wins, no fault.
  - mem_ack outside REQ is ignored.
- RESP:
  - resp_valid=1; data and fault outputs are held stable until resp_ready.
  - On resp_ready -> IDLE. No new request is accepted in the same cycle.
- Latency:
  - Accept at cycle N, mem_req at N+1, zero-wait ack at N+1, resp_valid at N+2.
  - Fault/non-memory accept at N gives resp_valid at N+1.
  - Minimum 3 cycles per transaction.
- Store lane rules (o = address[1:0]):
  - SB: wdata={4{sd[7:0]}}, wstrb=4'b0001<<o.
  - SH: wdata={2{sd[15:0]}}, wstrb=4'b0011<<{o[1],1'b0}.
  - SW: wdata=sd, wstrb=4'b1111.
- Load extract (o = address[1:0]):
  - Shift r = mem_rdata>>(8*o).
  - LB: sign-extend r[7:0].
  - LBU: zero-extend r[7:0].
  - LH: sign-extend r[15:0].
  - LHU: zero-extend r[15:0].
  - LW: r.
- Outputs are registered; no combinational path from req_valid or mem_ack to any output.

Test Plan:
- Reset, then SW addr=0x100 data=0xDEADBEEF, mem_ack same cycle as mem_req -> mem_addr=0x100, mem_we=1, wstrb=1111, wdata=0xDEADBEEF, resp_valid 2 cycles after accept, fault=0.
- SB addr=0x203 data=0x000000A5 -> mem_addr=0x200, wstrb=1000, wdata=0xA5A5A5A5.
- LB addr=0x301 with mem_rdata=0x12348000 -> resp_load_data=0xFFFFFF80; LBU with the same inputs -> 0x00000080; LH addr=0x302 with mem_rdata=0x8001_0000 -> 0xFFFF8001.
- LW addr=0x102 -> no mem_req, resp_valid next cycle, fault=1, cause=1; SH addr=0x101 -> cause=2.
- LW with mem_ack held low, TIMEOUT_CYCLES=16 -> mem_req high exactly 16 cycles, then resp fault cause=3; repeat with ack on the 16th cycle -> fault=0, data returned.
- Hold resp_ready=0 for 5 cycles -> resp_valid and data stable, req_ready=0. Assert reset during REQ -> mem_req=0 next cycle, no resp_valid, req_ready=1 the cycle after reset deasserts.
